register_file: RTL and testbench

Parametrised multi-port integer register file for the uPower core, replacing the file-backed register reader. It holds `NREGS` registers of `XLEN` bits in flops, with `NREAD` registered read ports and one write port. The write port applies load-width zero/sign extension, and same-cycle writes are forwarded to reads. A per-register pending scoreboard lets decode stall on registers that still have an outstanding load writeback. It sits between decode (read/scoreboard-set) and writeback (write).

---
 rtl/upower_pkg.sv | 41 ++++
 rtl/load_extend.sv | 52 +++++
 rtl/register_file.sv | 104 ++++++++++
 tb/tb_register_file.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared types and constants for the uPower integer register file.
package upower_pkg;

    // Default geometry of the integer register file.
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NREAD_DEF = 3;

    // Writeback extension mode. WM_RSV suppresses the write but still
    // releases the pending bit of the target register.
    typedef enum logic [2:0] {
        WM_DW  = 3'd0,
        WM_WZ  = 3'd1,
        WM_WS  = 3'd2,
        WM_HZ  = 3'd3,
        WM_HS  = 3'd4,
        WM_BZ  = 3'd5,
        WM_BS  = 3'd6,
        WM_RSV = 3'd7
    } wr_mode_t;

    // Primary opcodes of the loads that need a narrow writeback.
    localparam logic [5:0] OPC_LWZ = 6'd32;
    localparam logic [5:0] OPC_LBZ = 6'd34;
    localparam logic [5:0] OPC_LHZ = 6'd40;
    localparam logic [5:0] OPC_LHA = 6'd42;

    // Decode helper: map a load primary opcode to its writeback mode.
    function automatic wr_mode_t opcode_to_mode(input logic [5:0] opc);
        wr_mode_t m;
        case (opc)
            OPC_LBZ: m = WM_BZ;
            OPC_LHZ: m = WM_HZ;
            OPC_LHA: m = WM_HS;
            OPC_LWZ: m = WM_WZ;
            default: m = WM_DW;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-width zero/sign extension of writeback data.
// Shared by the register write path and the read forwarding path.
module load_extend
    import upower_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] data_i,
    input  wr_mode_t        mode_i,
    output logic [XLEN-1:0] data_o,
    output logic            we_o
);

    // Keep the low fw bits; fill the rest with zero or with bit fw-1.
    // A field at least as wide as XLEN passes the data through unchanged.
    function automatic logic [XLEN-1:0] ext_field(
        input logic [XLEN-1:0] d,
        input int              fw,
        input logic            sgn
    );
        logic [XLEN-1:0] r;
        logic            fill;
        fill = 1'b0;
        for (int b = 0; b < XLEN; b++) begin
            if (sgn && (b == fw - 1)) begin
                fill = d[b];
            end
        end
        for (int b = 0; b < XLEN; b++) begin
            r[b] = (b < fw) ? d[b] : fill;
        end
        return r;
    endfunction

    // Select the extension for the requested mode.
    always_comb begin
        data_o = data_i;
        we_o   = 1'b1;
        case (mode_i)
            WM_DW:   data_o = data_i;
            WM_WZ:   data_o = ext_field(data_i, 32, 1'b0);
            WM_WS:   data_o = ext_field(data_i, 32, 1'b1);
            WM_HZ:   data_o = ext_field(data_i, 16, 1'b0);
            WM_HS:   data_o = ext_field(data_i, 16, 1'b1);
            WM_BZ:   data_o = ext_field(data_i, 8, 1'b0);
            WM_BS:   data_o = ext_field(data_i, 8, 1'b1);
            WM_RSV:  we_o   = 1'b0;
            default: we_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// uPower integer register file: NREGS x XLEN flops, NREAD registered read
// ports with same-cycle write/scoreboard forwarding, one extending write
// port and a per-register load-pending scoreboard.
module register_file
    import upower_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD-1:0]      rd_en,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_pending,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [2:0]            wr_mode,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      pending_q;
    logic [NREGS-1:0]      pending_d;
    logic [NREAD*XLEN-1:0] rd_data_q;
    logic [NREAD*XLEN-1:0] rd_data_d;
    logic [NREAD-1:0]      rd_pending_q;
    logic [NREAD-1:0]      rd_pending_d;

    logic [XLEN-1:0]       ext_data_s;
    logic                  ext_we_s;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .data_i (wr_data),
        .mode_i (wr_mode_t'(wr_mode)),
        .data_o (ext_data_s),
        .we_o   (ext_we_s)
    );

    // Next register contents and scoreboard; a set beats a same-cycle clear.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_en) begin
            if (ext_we_s) begin
                regs_d[wr_addr] = ext_data_s;
            end else begin
                regs_d[wr_addr] = regs_q[wr_addr];
            end
            pending_d[wr_addr] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (sb_set) begin
            pending_d[sb_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // Read ports sample the next state, which forwards same-cycle writes
    // and scoreboard updates; disabled ports hold their last value.
    always_comb begin
        rd_data_d    = rd_data_q;
        rd_pending_d = rd_pending_q;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_en[i]) begin
                rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
                rd_pending_d[i]           = pending_d[rd_addr[i*AW +: AW]];
            end else begin
                rd_data_d[i*XLEN +: XLEN] = rd_data_q[i*XLEN +: XLEN];
                rd_pending_d[i]           = rd_pending_q[i];
            end
        end
    end

    // State registers; reset clears every register, pending bit and output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
            pending_q    <= {NREGS{1'b0}};
            rd_data_q    <= {(NREAD*XLEN){1'b0}};
            rd_pending_q <= {NREAD{1'b0}};
        end else begin
            regs_q       <= regs_d;
            pending_q    <= pending_d;
            rd_data_q    <= rd_data_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_pending = rd_pending_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREAD-1:0]      rd_en;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_pending;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [2:0]            wr_mode;
    logic                  sb_set;
    logic [AW-1:0]         sb_addr;

    int checks = 0;
    int errors = 0;

    logic [63:0] ext_exp [7];

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mode    (wr_mode),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] port_data(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    function automatic logic [63:0] port_pend(input int p);
        return {63'd0, rd_pending[p]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en  = 3'b000;
        wr_en  = 1'b0;
        sb_set = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p]           = en;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [2:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mode = m;
    endtask

    initial begin
        ext_exp[0] = 64'h0000_0000_8000_80F0;
        ext_exp[1] = 64'h0000_0000_8000_80F0;
        ext_exp[2] = 64'hFFFF_FFFF_8000_80F0;
        ext_exp[3] = 64'h0000_0000_0000_80F0;
        ext_exp[4] = 64'hFFFF_FFFF_FFFF_80F0;
        ext_exp[5] = 64'h0000_0000_0000_00F0;
        ext_exp[6] = 64'hFFFF_FFFF_FFFF_FFF0;

        rst     = 1'b1;
        rd_en   = 3'b000;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 64'd0;
        wr_mode = 3'd0;
        sb_set  = 1'b0;
        sb_addr = 5'd0;
        tick();
        tick();
        for (int p = 0; p < NREAD; p++) begin
            check_val("reset_data", port_data(p), 64'd0);
            check_val("reset_pend", port_pend(p), 64'd0);
        end
        rst = 1'b0;

        // Extension modes on r5.
        for (int m = 0; m < 7; m++) begin
            idle();
            do_write(5'd5, 64'h0000_0000_8000_80F0, 3'(m));
            tick();
            idle();
            set_rd(0, 1'b1, 5'd5);
            tick();
            check_val($sformatf("ext_mode%0d", m), port_data(0), ext_exp[m]);
        end

        // Mode 7: write suppressed but pending released.
        idle();
        sb_set  = 1'b1;
        sb_addr = 5'd5;
        tick();
        idle();
        do_write(5'd5, 64'h1111_2222_3333_4444, 3'd7);
        tick();
        idle();
        set_rd(0, 1'b1, 5'd5);
        tick();
        check_val("mode7_data", port_data(0), 64'hFFFF_FFFF_FFFF_FFF0);
        check_val("mode7_pend", port_pend(0), 64'd0);

        // Forwarding to two ports at once.
        idle();
        do_write(5'd7, 64'h1234, 3'd0);
        set_rd(0, 1'b1, 5'd7);
        set_rd(1, 1'b0, 5'd0);
        set_rd(2, 1'b1, 5'd7);
        tick();
        check_val("fwd_p0", port_data(0), 64'h1234);
        check_val("fwd_p2", port_data(2), 64'h1234);
        check_val("fwd_pend", port_pend(0), 64'd0);

        // Scoreboard set then read, then write with same-cycle read.
        idle();
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        tick();
        idle();
        set_rd(0, 1'b1, 5'd9);
        tick();
        check_val("sb_pend", port_pend(0), 64'd1);
        idle();
        do_write(5'd9, 64'hAB, 3'd0);
        set_rd(0, 1'b1, 5'd9);
        tick();
        check_val("sb_clr_pend", port_pend(0), 64'd0);
        check_val("sb_clr_data", port_data(0), 64'hAB);

        // Set/write collision on r3 with a same-cycle read on port 1.
        idle();
        do_write(5'd3, 64'h55, 3'd0);
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        set_rd(1, 1'b1, 5'd3);
        tick();
        check_val("coll_fwd_data", port_data(1), 64'h55);
        check_val("coll_fwd_pend", port_pend(1), 64'd1);
        idle();
        set_rd(1, 1'b1, 5'd3);
        tick();
        check_val("coll_data", port_data(1), 64'h55);
        check_val("coll_pend", port_pend(1), 64'd1);

        // Hold: port 1 disabled, address moved, old address rewritten.
        idle();
        set_rd(1, 1'b0, 5'd9);
        do_write(5'd3, 64'h77, 3'd0);
        tick();
        check_val("hold_data", port_data(1), 64'h55);
        check_val("hold_pend", port_pend(1), 64'd1);
        idle();
        set_rd(0, 1'b1, 5'd3);
        tick();
        check_val("after_hold_data", port_data(0), 64'h77);
        check_val("after_hold_pend", port_pend(0), 64'd0);

        // Mid-cycle asynchronous reset with a write in flight.
        idle();
        do_write(5'd10, 64'hDEAD_BEEF, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_p0", port_data(0), 64'd0);
        idle();
        tick();
        rst = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            idle();
            for (int p = 0; p < NREAD; p++) begin
                set_rd(p, 1'b1, 5'(r));
            end
            tick();
            for (int p = 0; p < NREAD; p++) begin
                check_val($sformatf("rst_r%0d_p%0d_data", r, p), port_data(p), 64'd0);
                check_val($sformatf("rst_r%0d_p%0d_pend", r, p), port_pend(p), 64'd0);
            end
        end

        // Normal operation resumes after reset release.
        idle();
        do_write(5'd0, 64'hCAFE, 3'd0);
        tick();
        idle();
        set_rd(2, 1'b1, 5'd0);
        tick();
        check_val("post_rst_r0", port_data(2), 64'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
